// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU issue sequencer.
//   fpu_op_e        : fpu_control encoding (values above NEG are illegal)
//   fpu_seq_state_e : sequencer FSM states
//   lat_of()        : per-op latency selected from the caller's latency parameters
package fpu_pkg;

  localparam int unsigned FPU_CTRL_W = 4;
  localparam int unsigned FPU_REG_W  = 5;

  typedef enum logic [FPU_CTRL_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    ABS = 4'd4,
    NEG = 4'd5
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } fpu_seq_state_e;

  // True for the six defined fpu_control codes.
  function automatic logic op_is_legal(logic [FPU_CTRL_W-1:0] ctrl);
    return ctrl <= FPU_CTRL_W'(5);
  endfunction

  // Latency of an op in cycles; illegal codes behave as a single-cycle op.
  function automatic int unsigned lat_of(fpu_op_e op, int unsigned add_lat,
                                         int unsigned mul_lat, int unsigned div_lat,
                                         int unsigned abs_lat);
    case (op)
      ADD, SUB: return add_lat;
      MUL:      return mul_lat;
      DIV:      return div_lat;
      ABS, NEG: return abs_lat;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (takes priority over dec)
//   dec        : decrement when non-zero
//   cnt, zero  : current count and cnt==0
module fpu_lat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset)                   cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue sequencer for the shared non-pipelined FPU: accepts one F-type op,
// starts the unit, waits its fixed latency, then holds a writeback request
// to the FP regfile until accepted. Flags FP RAW/WAW hazards while busy.
// Optional build macro FPU_ISSUE_B2B_EN: allow a new issue in the writeback
// cycle that the regfile accepts, removing the IDLE bubble.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   issue_valid/issue_ready            decode handshake; fpu_control, issue_fd payload
//   chk_fs/chk_ft/chk_fd, chk_en       decode register fields to hazard-check ({fd,ft,fs})
//   flush                              squash the in-flight op
//   unit_start/unit_op/unit_capture    FPU control
//   wb_valid/wb_reg/wb_ready           regfile writeback handshake
//   fp_hazard                          combinational stall request
//   busy                               sequencer not idle
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned ABS_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [FPU_CTRL_W-1:0] fpu_control,
  input  logic [FPU_REG_W-1:0]  issue_fd,
  input  logic [FPU_REG_W-1:0]  chk_fs,
  input  logic [FPU_REG_W-1:0]  chk_ft,
  input  logic [FPU_REG_W-1:0]  chk_fd,
  input  logic [2:0]            chk_en,
  input  logic                  flush,
  output logic                  unit_start,
  output logic [FPU_CTRL_W-1:0] unit_op,
  output logic                  unit_capture,
  output logic                  wb_valid,
  output logic [FPU_REG_W-1:0]  wb_reg,
  input  logic                  wb_ready,
  output logic                  fp_hazard,
  output logic                  busy
);

  localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MAX_DA  = (DIV_LAT > ABS_LAT) ? DIV_LAT : ABS_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > MAX_DA) ? MAX_AM : MAX_DA;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  fpu_seq_state_e          state_q, state_d;
  logic [FPU_CTRL_W-1:0]   op_q, op_d;
  logic [FPU_REG_W-1:0]    fd_q, fd_d;
  logic                    legal_q, legal_d;
  logic                    start_q, start_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    cnt_load;
  logic [CNT_W-1:0]        cnt_load_val;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_zero;
  logic                    accept;
  logic                    wb_fire;
  logic                    match;

  fpu_lat_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (state_q == EXEC),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign wb_fire = (state_q == WB) && wb_ready;

`ifdef FPU_ISSUE_B2B_EN
  assign issue_ready = ((state_q == IDLE) || wb_fire) && !reset;
`else
  assign issue_ready = (state_q == IDLE) && !reset;
`endif

  // A flush in the same cycle drops the accept.
  assign accept       = issue_valid && issue_ready && !flush;
  assign cnt_load_val = CNT_W'(lat_of(fpu_op_e'(fpu_control), ADD_LAT, MUL_LAT,
                                      DIV_LAT, ABS_LAT) - 32'd1);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      fd_q       <= '0;
      legal_q    <= 1'b0;
      start_q    <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      fd_q       <= fd_d;
      legal_q    <= legal_d;
      start_q    <= start_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fd_d       = fd_q;
    legal_d    = legal_q;
    start_d    = 1'b0;
    wb_valid_d = 1'b0;
    cnt_load   = 1'b0;
    case (state_q)
      IDLE: ;
      EXEC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          // Illegal ops finish here without a writeback.
          state_d    = legal_q ? WB : IDLE;
          wb_valid_d = legal_q;
        end
      end
      WB: begin
        wb_valid_d = 1'b1;
        if (flush || wb_ready) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d  = EXEC;
      op_d     = fpu_control;
      fd_d     = issue_fd;
      legal_d  = op_is_legal(fpu_control);
      start_d  = op_is_legal(fpu_control);
      cnt_load = 1'b1;
    end
  end

  assign match = (chk_en[0] && (chk_fs == fd_q)) ||
                 (chk_en[1] && (chk_ft == fd_q)) ||
                 (chk_en[2] && (chk_fd == fd_q));

`ifdef FPU_ISSUE_B2B_EN
  // The write-first regfile forwards the completing write, so no stall then.
  assign fp_hazard = (state_q != IDLE) && match && !reset && !wb_fire;
`else
  assign fp_hazard = (state_q != IDLE) && match && !reset;
`endif

  // Capture on the last latency cycle unless squashed that same cycle.
  assign unit_capture = (state_q == EXEC) && cnt_zero && legal_q && !flush && !reset;

  assign unit_start = start_q;
  assign unit_op    = op_q;
  assign wb_valid   = wb_valid_q;
  assign wb_reg     = fd_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Self-checking bench for fpu_issue_seq: directed scenarios followed by
// random traffic, all checked every cycle against a transaction-level model
// that tracks the in-flight op by its age since acceptance.
module tb_fpu_issue_seq;

`ifdef FPU_ISSUE_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, issue_valid, flush, wb_ready;
  logic [3:0] fpu_control;
  logic [4:0] issue_fd, chk_fs, chk_ft, chk_fd;
  logic [2:0] chk_en;
  logic       issue_ready, unit_start, unit_capture, wb_valid, fp_hazard, busy;
  logic [3:0] unit_op;
  logic [4:0] wb_reg;

  int checks   = 0;
  int failures = 0;
  string phase = "init";

  // Model of the single in-flight op.
  bit         m_pend  = 1'b0;
  bit         m_legal = 1'b0;
  int         m_age   = 0;
  int         m_lat   = 1;
  logic [3:0] m_op    = 4'd0;
  logic [4:0] m_fd    = 5'd0;

  fpu_issue_seq dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .fpu_control(fpu_control), .issue_fd(issue_fd), .chk_fs(chk_fs), .chk_ft(chk_ft),
    .chk_fd(chk_fd), .chk_en(chk_en), .flush(flush), .unit_start(unit_start),
    .unit_op(unit_op), .unit_capture(unit_capture), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_ready(wb_ready), .fp_hazard(fp_hazard), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int lat_f(logic [3:0] c);
    case (c)
      4'd0, 4'd1: return 2;
      4'd2:       return 4;
      4'd3:       return 16;
      4'd4, 4'd5: return 1;
      default:    return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h t=%0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; issue_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    fpu_control = 4'd0; issue_fd = 5'd0;
    chk_fs = 5'd0; chk_ft = 5'd0; chk_fd = 5'd0; chk_en = 3'b000;
  endtask

  // Check outputs mid-cycle, then advance the model across the next posedge.
  task automatic cycle();
    bit e_wb, e_start, e_cap, b2b_fire, e_ready, mt, e_haz, acc, done;
    @(negedge clk);
    e_wb     = m_pend && m_legal && (m_age >= m_lat);
    e_start  = m_pend && m_legal && (m_age == 0);
    e_cap    = m_pend && m_legal && (m_age == m_lat - 1) && !flush && !reset;
    b2b_fire = B2B && e_wb && wb_ready;
    e_ready  = (!m_pend || b2b_fire) && !reset;
    mt       = (chk_en[0] && chk_fs == m_fd) || (chk_en[1] && chk_ft == m_fd) ||
               (chk_en[2] && chk_fd == m_fd);
    e_haz    = m_pend && mt && !reset && !b2b_fire;
    chk("issue_ready",  8'(issue_ready),  8'(e_ready));
    chk("busy",         8'(busy),         8'(m_pend));
    chk("unit_start",   8'(unit_start),   8'(e_start));
    chk("unit_capture", 8'(unit_capture), 8'(e_cap));
    chk("wb_valid",     8'(wb_valid),     8'(e_wb));
    chk("fp_hazard",    8'(fp_hazard),    8'(e_haz));
    if (e_wb)   chk("wb_reg",  8'(wb_reg),  8'(m_fd));
    if (m_pend) chk("unit_op", 8'(unit_op), 8'(m_op));
    acc  = issue_valid && e_ready && !flush;
    done = flush || (e_wb && wb_ready) || (!m_legal && m_age == 0);
    @(posedge clk);
    if (reset) begin
      m_pend = 1'b0; m_op = 4'd0; m_fd = 5'd0; m_legal = 1'b0;
    end else if (acc) begin
      m_pend = 1'b1; m_age = 0; m_op = fpu_control; m_fd = issue_fd;
      m_legal = (fpu_control <= 4'd5); m_lat = lat_f(fpu_control);
    end else if (m_pend && done) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_age++;
    end
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [4:0] fd);
    issue_valid = 1'b1; fpu_control = c; issue_fd = fd;
    cycle();
    issue_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    phase = "reset";
    run(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_unit_op", 8'(unit_op), 8'd0);
    chk("rst_wb_reg",  8'(wb_reg),  8'd0);
    chk("rst_ready",   8'(issue_ready), 8'd1);
    run(1);

    phase = "mul";
    issue(4'd2, 5'd3);
    run(4);
    wb_ready = 1'b1;
    run(1);
    wb_ready = 1'b0;
    run(2);

    phase = "div_hazard";
    chk_en = 3'b001; chk_fs = 5'd7;
    issue(4'd3, 5'd7);
    run(16);
    chk_fs = 5'd8; issue_valid = 1'b1; fpu_control = 4'd0; issue_fd = 5'd9;
    run(5);
    issue_valid = 1'b0;
    chk_fs = 5'd7; wb_ready = 1'b1;
    run(1);
    idle_inputs();
    run(2);

    phase = "flush_exec";
    issue(4'd3, 5'd4);
    run(2);
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    run(3);

    phase = "illegal";
    chk_en = 3'b100; chk_fd = 5'd6;
    issue(4'd9, 5'd6);
    run(3);
    idle_inputs();

    phase = "flush_accept";
    flush = 1'b1;
    issue(4'd0, 5'd5);
    flush = 1'b0;
    run(2);

    phase = "reset_mid";
    issue(4'd2, 5'd11);
    run(2);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(2);

    phase = "b2b";
    issue(4'd0, 5'd1);
    run(2);
    chk_en = 3'b010; chk_ft = 5'd1;
    wb_ready = 1'b1; issue_valid = 1'b1; fpu_control = 4'd0; issue_fd = 5'd2;
    run(1);
    idle_inputs();
    run(6);
    wb_ready = 1'b1;
    run(2);
    idle_inputs();
    run(2);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      issue_valid = $urandom_range(0, 1);
      fpu_control = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15))
                                                : 4'($urandom_range(0, 5));
      issue_fd    = 5'($urandom_range(0, 7));
      chk_fs      = 5'($urandom_range(0, 7));
      chk_ft      = 5'($urandom_range(0, 7));
      chk_fd      = 5'($urandom_range(0, 7));
      chk_en      = 3'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 19) == 0);
      wb_ready    = $urandom_range(0, 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
